// File: rtl/sram_pkg.sv
// Shared types and sizing helpers for the 1RW masked SRAM model.
package sram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    function automatic int seg_count(input int width, input int gran);
        return (width + gran - 1) / gran;
    endfunction

    function automatic int addr_width(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read return pipe: LAT stages of valid/data; data registers only load on a valid
// beat so the output holds the last read while rvalid is low.
module sram_rd_pipe
    import sram_pkg::*;
#(
    parameter int WIDTH = 47,
    parameter int LAT   = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             rd_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             rvalid_o
);

    logic [LAT-1:0]   vld_q;
    logic [WIDTH-1:0] dat_q [LAT];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= rd_i;
            if (rd_i) begin
                dat_q[0] <= data_i;
            end
            for (int i = 1; i < LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end
    end

    assign rdata_o  = dat_q[LAT-1];
    assign rvalid_o = vld_q[LAT-1];

endmodule

// File: rtl/sram_1rw_masked_init_ext.sv
// Single-port SRAM model with segment write mask, 1/2-cycle read latency and clear engine.
//   state    | meaning
//   ST_CLEAR | writing INIT_VAL to ram[ptr], one word per cycle, accesses refused
//   ST_IDLE  | ready, accepting reads and masked writes
module sram_1rw_masked_init_ext
    import sram_pkg::*;
#(
    parameter int               DEPTH     = 256,
    parameter int               WIDTH     = 47,
    parameter int               MASK_GRAN = 8,
    parameter int               READ_LAT  = 1,
    parameter logic [WIDTH-1:0] INIT_VAL  = '0,
    localparam int              SEG       = seg_count(WIDTH, MASK_GRAN),
    localparam int              AW        = addr_width(DEPTH)
) (
    input  logic             RW0_clk,
    input  logic             RW0_reset,
    input  logic [AW-1:0]    RW0_addr,
    input  logic             RW0_en,
    input  logic             RW0_wmode,
    input  logic [SEG-1:0]   RW0_wmask,
    input  logic [WIDTH-1:0] RW0_wdata,
    output logic [WIDTH-1:0] RW0_rdata,
    output logic             RW0_rvalid,
    output logic             RW0_ready,
    input  logic             init_req,
    output logic             init_done
);

    localparam logic [AW:0]   DEPTH_W    = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_LAST   = AW'(DEPTH - 1);
    localparam logic [AW-1:0] PTR_PENULT = AW'(DEPTH - 2);

    logic [WIDTH-1:0] ram [DEPTH];

    state_e           state_q;
    logic [AW-1:0]    ptr_q;
    logic             ready_q;
    logic             init_done_q;

    logic             in_range;
    logic             acc;
    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] bit_mask;
    logic [WIDTH-1:0] rd_word;

    always_comb begin
        bit_mask = '0;
        for (int b = 0; b < WIDTH; b++) begin
            bit_mask[b] = RW0_wmask[b / MASK_GRAN];
        end
    end

    assign in_range = {1'b0, RW0_addr} < DEPTH_W;
    assign acc      = RW0_en && ready_q;
    assign wr_en    = acc && RW0_wmode && in_range;
    assign rd_en    = acc && !RW0_wmode;
    assign rd_word  = in_range ? ram[RW0_addr] : '0;

    // init_done is loaded one cycle early so it is high while ptr sits on the last word
    always_ff @(posedge RW0_clk or posedge RW0_reset) begin
        if (RW0_reset) begin
            state_q     <= ST_CLEAR;
            ptr_q       <= '0;
            ready_q     <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    if (ptr_q == PTR_LAST) begin
                        state_q     <= ST_IDLE;
                        ptr_q       <= '0;
                        ready_q     <= 1'b1;
                        init_done_q <= 1'b0;
                    end else begin
                        ptr_q       <= ptr_q + AW'(1);
                        init_done_q <= (ptr_q == PTR_PENULT);
                    end
                end
                ST_IDLE: begin
                    init_done_q <= 1'b0;
                    if (init_req) begin
                        state_q <= ST_CLEAR;
                        ready_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_CLEAR;
                end
            endcase
        end
    end

    always_ff @(posedge RW0_clk) begin
        if (state_q == ST_CLEAR) begin
            ram[ptr_q] <= INIT_VAL;
        end else if (wr_en) begin
            ram[RW0_addr] <= (ram[RW0_addr] & ~bit_mask) | (RW0_wdata & bit_mask);
        end
    end

    sram_rd_pipe #(
        .WIDTH (WIDTH),
        .LAT   (READ_LAT)
    ) u_rd_pipe (
        .clk_i    (RW0_clk),
        .rst_i    (RW0_reset),
        .rd_i     (rd_en),
        .data_i   (rd_word),
        .rdata_o  (RW0_rdata),
        .rvalid_o (RW0_rvalid)
    );

    assign RW0_ready = ready_q;
    assign init_done = init_done_q;

endmodule
